seq_burst_gen: RTL and testbench

Stimulus-side counterpart of the sequence-match counter/detector FSM. On command it drives a burst of `valid`/`num` beats containing an exact, programmed number of beats equal to `seq`. It then drops `valid`, counts the detector's `hit` pulse train, and reports whether the hit count matched the programmed match count. It sits in front of the detector as a self-checking traffic source for bring-up and on-chip test.

---
 rtl/seq_burst_gen.sv | 185 ++++++++++++++++++
 tb/tb_seq_burst_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module   : seq_burst_gen
//  Purpose  : Self-checking traffic source for the sequence-match detector.
//             On command it sends a burst of valid/num beats in which exactly
//             min(cmd_hits, cmd_len) beats equal the programmed pattern. Then
//             it counts the detector's hit pulse train and reports whether the
//             count matched.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock     in   1  rising-edge clock
//    reset     in   1  synchronous, active-low reset
//    start     in   1  command strobe, sampled only while idle
//    cmd_len   in   4  number of valid beats (0..15)
//    cmd_seq   in   4  pattern value to match
//    cmd_hits  in   4  requested matching beats (clamped to cmd_len)
//    valid     out  1  beat qualifier to the detector (registered)
//    num       out  4  beat value to the detector (registered)
//    seq       out  4  pattern presented to the detector
//    hit       in   1  detector hit output
//    busy      out  1  high whenever the block is not idle
//    done      out  1  one-cycle result strobe
//    pass      out  1  hit count equalled the expected count
//    hit_cnt   out  4  observed hit cycles, saturating at 15
// ============================================================================
module seq_burst_gen #(
    parameter logic [3:0] LFSR_SEED = 4'h9,
    parameter logic [7:0] TIMEOUT   = 8'd32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cmd_len,
    input  logic [3:0] cmd_seq,
    input  logic [3:0] cmd_hits,
    output logic       valid,
    output logic [3:0] num,
    output logic [3:0] seq,
    input  logic       hit,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] hit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] c_timer_last = TIMEOUT - 8'd1;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_len;
    logic [3:0] r_exp;
    logic [3:0] r_beat;
    logic [7:0] r_timer;
    logic       r_hit_seen;
    logic [3:0] r_lfsr;
    logic       r_valid;
    logic [3:0] r_num;
    logic [3:0] r_seq;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_hit_cnt;

    logic       w_send_last;
    logic       w_check_exit;
    logic [3:0] w_exp_clamped;
    logic [3:0] w_lfsr_nxt;
    logic [3:0] w_filler;

    // ------------------------------------------------------------------------
    // Next-state and datapath helpers
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        // SEND spends one extra cycle after the last beat (beat == len) so
        // that valid is already low in the first CHECK cycle. A zero-length
        // command uses that same single cycle, keeping CHECK entry at T+L+1.
        w_send_last   = (r_beat == r_len);
        // Falling edge of the hit train, or the timeout bound.
        w_check_exit  = (r_hit_seen && !hit) || (r_timer == c_timer_last);
        w_exp_clamped = (cmd_hits > cmd_len) ? cmd_len : cmd_hits;
        // Fibonacci LFSR, x^4 + x^3 + 1.
        w_lfsr_nxt    = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        // Filler must never match: substitute the complement on collision.
        w_filler      = (r_lfsr != r_seq) ? r_lfsr : ~r_seq;

        case (r_state)
            S_IDLE:  if (start)        w_state_nxt = S_SEND;
            S_SEND:  if (w_send_last)  w_state_nxt = S_CHECK;
            S_CHECK: if (w_check_exit) w_state_nxt = S_DONE;
            S_DONE:                    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and registered datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_len      <= 4'd0;
            r_exp      <= 4'd0;
            r_beat     <= 4'd0;
            r_timer    <= 8'd0;
            r_hit_seen <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_valid    <= 1'b0;
            r_num      <= 4'd0;
            r_seq      <= 4'd0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_hit_cnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_seq      <= cmd_seq;
                        r_len      <= cmd_len;
                        r_exp      <= w_exp_clamped;
                        r_beat     <= 4'd0;
                        r_hit_cnt  <= 4'd0;
                        r_timer    <= 8'd0;
                        r_hit_seen <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end

                S_SEND: begin
                    if (w_send_last) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                        // Matching beats go first, fillers after.
                        r_num   <= (r_beat < r_exp) ? r_seq : w_filler;
                        r_beat  <= r_beat + 4'd1;
                        r_lfsr  <= w_lfsr_nxt;
                    end
                end

                S_CHECK: begin
                    r_valid <= 1'b0;
                    r_timer <= r_timer + 8'd1;
                    if (hit) begin
                        if (r_hit_cnt != 4'hF) begin
                            r_hit_cnt <= r_hit_cnt + 4'd1;
                        end
                        r_hit_seen <= 1'b1;
                    end
                end

                S_DONE: begin
                    // hit_cnt here already includes a hit on the last CHECK cycle.
                    r_done <= 1'b1;
                    r_pass <= (r_hit_cnt == r_exp);
                end

                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid   = r_valid;
    assign num     = r_num;
    assign seq     = r_seq;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign pass    = r_pass;
    assign hit_cnt = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_burst_gen
//  Purpose  : Self-checking bench for seq_burst_gen. A transaction-level
//             model predicts the beat list, the CHECK exit point and the
//             final count of each command; a negedge process compares every
//             cycle against those predictions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_burst_gen;

    localparam logic [3:0] c_seed    = 4'h9;
    localparam int         c_timeout = 32;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic [3:0] cmd_len  = 4'd0;
    logic [3:0] cmd_seq  = 4'd0;
    logic [3:0] cmd_hits = 4'd0;
    logic       hit      = 1'b0;
    logic       valid;
    logic [3:0] num;
    logic [3:0] seq;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] hit_cnt;

    seq_burst_gen #(
        .LFSR_SEED (c_seed),
        .TIMEOUT   (8'(c_timeout))
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .cmd_len  (cmd_len),
        .cmd_seq  (cmd_seq),
        .cmd_hits (cmd_hits),
        .valid    (valid),
        .num      (num),
        .seq      (seq),
        .hit      (hit),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .hit_cnt  (hit_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Expectations for the current cycle, written just after each posedge.
    logic       chk_en    = 1'b0;
    logic       e_valid   = 1'b0;
    logic       e_busy    = 1'b0;
    logic       e_done    = 1'b0;
    logic [3:0] e_num     = 4'd0;
    logic [3:0] e_seq     = 4'd0;
    logic       chk_res   = 1'b0;
    logic       e_pass    = 1'b0;
    logic [3:0] e_hit_cnt = 4'd0;

    // Model state carried between commands.
    logic [3:0] m_lfsr    = c_seed;
    logic [3:0] h_seq     = 4'd0;
    logic       h_pass    = 1'b0;
    logic [3:0] h_hit_cnt = 4'd0;

    logic [63:0] bts;
    int          iex;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] lfsr_step(input logic [3:0] v);
        return {v[2:0], v[3] ^ v[2]};
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("valid", int'(valid), int'(e_valid));
            chk("busy",  int'(busy),  int'(e_busy));
            chk("done",  int'(done),  int'(e_done));
            chk("seq",   int'(seq),   int'(e_seq));
            if (e_valid) chk("num", int'(num), int'(e_num));
            if (chk_res) begin
                chk("pass",    int'(pass),    int'(e_pass));
                chk("hit_cnt", int'(hit_cnt), int'(e_hit_cnt));
            end
        end
    end

    task automatic idle_cycle(input logic junk_hit);
        @(posedge clock); #1;
        e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_seq = h_seq;
        chk_res = 1'b1; e_pass = h_pass; e_hit_cnt = h_hit_cnt;
        start = 1'b0;
        hit   = junk_hit;
    endtask

    // k_train < 0: loopback (hit train length = beats equal to the pattern).
    // rst_at >= 0: reset is sampled low at that edge relative to the accept.
    task automatic run_cmd(input int L, input int sq, input int hits, input int k_train,
                           input bit junk, input int rst_at,
                           output logic [63:0] o_beats, output int o_iexit);
        int         ex, s_edge, x_edge, i_exit, cnt, k, h0;
        bit         seen;
        logic [3:0] beats [16];
        logic       hplan [80];

        ex = (hits < L) ? hits : L;
        o_beats = 64'd0;
        for (int b = 0; b < 16; b++) beats[b] = 4'd0;
        for (int b = 0; b < L; b++) begin
            beats[b] = (b < ex) ? 4'(sq) : ((m_lfsr != 4'(sq)) ? m_lfsr : ~4'(sq));
            m_lfsr   = lfsr_step(m_lfsr);
            o_beats[b*4 +: 4] = beats[b];
        end

        k = k_train;
        if (k < 0) begin
            k = 0;
            for (int b = 0; b < L; b++) if (beats[b] == 4'(sq)) k++;
        end

        s_edge = L + 1;
        for (int r = 0; r < 80; r++) hplan[r] = 1'b0;
        if (junk) for (int r = 1; r <= s_edge; r++) hplan[r] = ($urandom_range(0, 2) == 0);
        h0 = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) hplan[s_edge + h0 + i] = 1'b1;

        seen = 1'b0; cnt = 0; i_exit = 0;
        for (int i = 1; i <= c_timeout && i_exit == 0; i++) begin
            if (hplan[s_edge + i]) cnt++;
            if ((seen && !hplan[s_edge + i]) || i == c_timeout) i_exit = i;
            if (hplan[s_edge + i]) seen = 1'b1;
        end
        if (cnt > 15) cnt = 15;
        x_edge  = s_edge + i_exit;
        o_iexit = i_exit;

        start = 1'b1; cmd_len = 4'(L); cmd_seq = 4'(sq); cmd_hits = 4'(hits); hit = hplan[0];
        for (int r = 0; r <= x_edge + 1; r++) begin
            @(posedge clock); #1;
            if (r == rst_at) begin
                e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_seq = 4'd0;
                chk_res = 1'b1; e_pass = 1'b0; e_hit_cnt = 4'd0;
                chk("num_after_reset", int'(num), 0);
                reset = 1'b1; start = 1'b0; hit = 1'b0;
                m_lfsr = c_seed; h_seq = 4'd0; h_pass = 1'b0; h_hit_cnt = 4'd0;
                return;
            end
            e_busy  = (r <= x_edge);
            e_done  = (r == x_edge + 1);
            e_valid = (r >= 1 && r <= L);
            if (e_valid) e_num = beats[r - 1];
            e_seq   = 4'(sq);
            chk_res = (r == 0 || r == x_edge + 1);
            if (r == 0) begin
                e_pass = 1'b0; e_hit_cnt = 4'd0;
            end else begin
                e_pass = (cnt == ex); e_hit_cnt = 4'(cnt);
            end
            start    = junk && (r + 1 <= x_edge) && ($urandom_range(0, 3) == 0);
            cmd_len  = 4'($urandom);
            cmd_seq  = 4'($urandom);
            cmd_hits = 4'($urandom);
            hit      = (r + 1 < 80) ? hplan[r + 1] : 1'b0;
            if (r + 1 == rst_at) reset = 1'b0;
        end
        h_seq = 4'(sq); h_pass = (cnt == ex); h_hit_cnt = 4'(cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_seq = 4'd0;
        chk_res = 1'b1; e_pass = 1'b0; e_hit_cnt = 4'd0;
        chk_en  = 1'b1;
        chk("num_reset", int'(num), 0);
        reset = 1'b1;
        idle_cycle(1'b0);

        // Basic burst: beats 5,5 then fillers 6,13 from seed 9.
        run_cmd(4, 5, 2, -1, 1'b0, -1, bts, iex);
        chk("basic_beats_model", int'(bts[15:0]), 16'hD655);
        chk("basic_hit_cnt", int'(hit_cnt), 2);
        chk("basic_pass", int'(pass), 1);
        idle_cycle(1'b0);

        // No matches: timeout after 32 CHECK cycles.
        run_cmd(3, 7, 0, -1, 1'b0, -1, bts, iex);
        chk("nomatch_exit_model", iex, 32);
        chk("nomatch_pass", int'(pass), 1);
        chk("nomatch_hit_cnt", int'(hit_cnt), 0);

        // Clamping: all three beats match.
        run_cmd(3, 10, 6, -1, 1'b0, -1, bts, iex);
        chk("clamp_beats_model", int'(bts[11:0]), 12'hAAA);
        chk("clamp_hit_cnt", int'(hit_cnt), 3);
        chk("clamp_pass", int'(pass), 1);

        // Error detection: too many hits, then saturation.
        run_cmd(4, 5, 2, 4, 1'b0, -1, bts, iex);
        chk("err4_hit_cnt", int'(hit_cnt), 4);
        chk("err4_pass", int'(pass), 0);
        run_cmd(4, 5, 2, 20, 1'b0, -1, bts, iex);
        chk("err20_hit_cnt", int'(hit_cnt), 15);
        chk("err20_pass", int'(pass), 0);

        // Junk start/hit while busy.
        run_cmd(6, 3, 2, -1, 1'b1, -1, bts, iex);

        // Reset on the third SEND cycle, then the filler restarts from the seed.
        run_cmd(8, 4, 3, -1, 1'b0, 3, bts, iex);
        idle_cycle(1'b0);
        run_cmd(3, 2, 0, -1, 1'b0, -1, bts, iex);
        chk("post_reset_filler_model", int'(bts[3:0]), 9);

        // Zero-length commands.
        run_cmd(0, 6, 3, 0, 1'b0, -1, bts, iex);
        chk("zero_pass", int'(pass), 1);
        run_cmd(0, 6, 3, 1, 1'b0, -1, bts, iex);
        chk("zero_hit_pass", int'(pass), 0);
        chk("zero_hit_cnt", int'(hit_cnt), 1);

        // Randomized commands with random gaps.
        for (int n = 0; n < 24; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) idle_cycle(1'($urandom_range(0, 1)));
            run_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                    ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 20)),
                    1'b1, -1, bts, iex);
        end
        idle_cycle(1'b0);
        idle_cycle(1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
